// File: rtl/chip8_display_scanout.sv
// chip8_display_scanout
//
// Takes a snapshot of the 64x32 CHIP-8 framebuffer and streams it out one
// pixel per handshake in raster order, replicating each source pixel into a
// SCALE x SCALE block.
//
// Ports
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   start        frame request, only looked at while idle
//   display_in   framebuffer, pixel (x,y) at bit y*64+x, 1 = lit
//   busy         high while a frame is in progress
//   pix_valid    current beat valid
//   pix_ready    sink ready
//   pix_data     pixel value of the current beat
//   out_x        output column 0..64*SCALE-1
//   out_y        output row 0..32*SCALE-1
//   sof          first beat of the frame
//   eol          last beat of an output line
//   frame_done   one-cycle pulse after the last beat is accepted
//   dbg_state_o  FSM state, 1 = STREAM
//
// Handshake: a beat transfers on a rising edge where pix_valid && pix_ready.
// While pix_valid is high and pix_ready is low, every output holds. pix_valid
// never drops before its beat is accepted. No output depends combinationally
// on pix_ready, start or display_in.
//
// SCALE must be in 1..8.

module chip8_display_scanout #(
    parameter int SCALE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [2047:0] display_in,
    output logic          busy,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic          pix_data,
    output logic [8:0]    out_x,
    output logic [7:0]    out_y,
    output logic          sof,
    output logic          eol,
    output logic          frame_done,
    output logic          dbg_state_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [8:0] LAST_X = 9'(64 * SCALE - 1);
    localparam logic [2:0] LAST_S = 3'(SCALE - 1);

    state_t        state_q, state_d;
    logic [2047:0] snap_q, snap_d;
    // px/py: source pixel; sx/sy: replica position inside the SCALE block.
    logic [5:0]    px_q, px_d;
    logic [4:0]    py_q, py_d;
    logic [2:0]    sx_q, sx_d;
    logic [2:0]    sy_q, sy_d;
    logic [8:0]    out_x_q, out_x_d;
    logic [7:0]    out_y_q, out_y_d;
    logic          frame_done_q, frame_done_d;

    logic last_sx, last_sy, last_px, last_py, line_end, frame_end;

    assign last_sx   = (sx_q == LAST_S);
    assign last_sy   = (sy_q == LAST_S);
    assign last_px   = (px_q == 6'd63);
    assign last_py   = (py_q == 5'd31);
    assign line_end  = last_sx && last_px;
    assign frame_end = line_end && last_sy && last_py;

    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        px_d         = px_q;
        py_d         = py_q;
        sx_d         = sx_q;
        sy_d         = sy_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    snap_d  = display_in;
                    px_d    = '0;
                    py_d    = '0;
                    sx_d    = '0;
                    sy_d    = '0;
                    out_x_d = '0;
                    out_y_d = '0;
                end
            end
            STREAM: begin
                if (pix_ready) begin
                    if (frame_end) begin
                        // Counters go back to 0 so idle outputs read as 0.
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                        px_d         = '0;
                        py_d         = '0;
                        sx_d         = '0;
                        sy_d         = '0;
                        out_x_d      = '0;
                        out_y_d      = '0;
                    end else begin
                        sx_d = last_sx ? 3'd0 : sx_q + 3'd1;
                        if (last_sx) begin
                            px_d = last_px ? 6'd0 : px_q + 6'd1;
                        end
                        if (line_end) begin
                            out_x_d = '0;
                            out_y_d = out_y_q + 8'd1;
                            sy_d    = last_sy ? 3'd0 : sy_q + 3'd1;
                            if (last_sy) begin
                                py_d = py_q + 5'd1;
                            end
                        end else begin
                            out_x_d = out_x_q + 9'd1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            snap_q       <= '0;
            px_q         <= '0;
            py_q         <= '0;
            sx_q         <= '0;
            sy_q         <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            px_q         <= px_d;
            py_q         <= py_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign busy        = (state_q == STREAM);
    assign pix_valid   = (state_q == STREAM);
    assign pix_data    = (state_q == STREAM) && snap_q[{py_q, px_q}];
    assign out_x       = out_x_q;
    assign out_y       = out_y_q;
    assign sof         = (state_q == STREAM) && (out_x_q == 9'd0) && (out_y_q == 8'd0);
    assign eol         = (state_q == STREAM) && (out_x_q == LAST_X);
    assign frame_done  = frame_done_q;
    assign dbg_state_o = (state_q == STREAM);

endmodule

// File: doc/chip8_display_scanout.md
# chip8_display_scanout

Read-side counterpart of the CHIP-8 sprite drawer. The drawer writes the 2048-bit monochrome framebuffer. This block snapshots that framebuffer on request and streams it out one pixel per handshake, in raster order, with optional integer upscaling. It sits between the framebuffer register and any video or serial sink (VGA pixel pipe, LED-matrix shifter, testbench frame dumper).

## Interface
Parameters:
- SCALE, default 1: integer pixel replication factor, legal 1..8. Output frame is 64*SCALE by 32*SCALE.

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  frame request, sampled only in IDLE
- display_in  in  2048  framebuffer; pixel (x,y) at bit y*64+x, 1 = lit
- busy  out  1  high while a frame is in progress
- pix_valid  out  1  current beat valid
- pix_ready  in  1  sink accepts the beat when pix_valid && pix_ready
- pix_data  out  1  pixel value
- out_x  out  9  output column, 0..64*SCALE-1
- out_y  out  8  output row, 0..32*SCALE-1
- sof  out  1  high on the beat with out_x=0 and out_y=0
- eol  out  1  high on the beat with out_x=64*SCALE-1
- frame_done  out  1  one-cycle pulse after the last beat is accepted

## Operation
- States: IDLE and STREAM.
- Reset (rst_n=0 at a clock edge): state goes to IDLE, the snapshot clears to 0, and all counters clear to 0.
  - Outputs after reset: busy, pix_valid, pix_data, out_x, out_y, sof, eol and frame_done are all 0.
- IDLE, start=1: the block captures the snapshot from display_in, clears the counters and moves to STREAM with busy=1.
- IDLE, start=0: the block holds.
- STREAM:
  - pix_valid=1.
  - pix_data = snapshot[(py*64)+px], where px = out_x/SCALE and py = out_y/SCALE.
  - Division is not permitted. Track px, py and the sub-counters sx, sy (0..SCALE-1) explicitly.
- Advance on a handshake, in this order:
  - sx increments. When sx wraps, px increments.
  - At the end of a line (out_x = 64*SCALE-1), out_x goes to 0 and out_y increments.
  - py advances when sy wraps.
- Last beat (out_x = 64*SCALE-1, out_y = 32*SCALE-1) accepted:
  - Next state IDLE, with pix_valid=0 and busy=0.
  - frame_done=1 for exactly one cycle.
  - Counters return to 0.
- start is ignored in STREAM and does not queue.
- display_in changes during STREAM have no effect. Output comes only from the snapshot (no tearing).
- pix_data, out_x, out_y, sof and eol derive only from registered state. There is no combinational path from pix_ready, start or display_in to any output.
- Stall: while pix_valid && !pix_ready, every output holds its value.
- Reset mid-frame: the block aborts at the reset edge with the full reset values. No frame_done is issued for the aborted frame.

## Timing
- start sampled at edge N: pix_valid=1 with sof=1 from cycle N+1.
- Throughput is 1 beat per cycle with pix_ready held high.
- A frame takes 2048*SCALE² beats.
- With pix_ready held high: last beat at cycle N+2048*SCALE², and frame_done high in cycle N+2048*SCALE²+1.
- A start asserted in the frame_done cycle is accepted: the block is IDLE then. The next sof comes one cycle later. The minimum inter-frame gap is 1 cycle.
- Each stall cycle extends the frame by one cycle.

## Test plan
- Reset: hold rst_n=0 for 2 cycles mid-frame → next cycle busy=0, pix_valid=0, frame_done=0, out_x=0, out_y=0. No frame_done follows.
- SCALE=1 corner pixels: display_in has only bit 0 and bit 2047 set, pix_ready=1, start at cycle 0.
  - Beat 1: pix_data=1, sof=1.
  - Beat 2048: pix_data=1, eol=1, out_x=63, out_y=31.
  - All other beats 0. eol fires on exactly 32 beats.
  - frame_done at cycle 2049.
- Backpressure: pix_ready pattern 1,0,0,1 repeating with a checkerboard display_in → outputs stable across stall cycles. The captured stream equals the checkerboard with no drop or duplicate. The frame takes 2x the cycles.
- Snapshot: start with all-zero display_in, then switch display_in to all ones at beat 100 → all 2048 beats read 0.
- SCALE=2: only pixel (1,0) lit → pix_data=1 exactly at (out_x,out_y) = (2,0),(3,0),(2,1),(3,1). The frame is 8192 beats, and eol is at out_x=127.
- Start handling: start pulses during STREAM → ignored, one frame only. Start in the frame_done cycle → sof on the next cycle.
